// File: rtl/fpu8_op_sequencer.sv
// fpu8_op_sequencer
// Issue/sequencing stage in front of the 8-bit FP datapath (s|eeee|mmm, bias 7).
// It accepts one request at a time, screens the registered operands for
// illegal ops and FP exceptions, dispatches legal requests to the multi-cycle
// core, and returns a result plus a status code through a valid/ready handshake.
module fpu8_op_sequencer #(
  parameter int CORE_TIMEOUT = 15,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             core_start,
  output logic [1:0]       core_op,
  output logic [7:0]       core_a,
  output logic [7:0]       core_b,
  input  logic             core_done,
  input  logic [7:0]       core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [1:0]       res_status,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_FP_EXC  = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [7:0] CANON_NAN = 8'h7F;
  localparam logic [7:0] TMO_LIMIT = CORE_TIMEOUT[7:0];

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // NaN: exponent all ones with a non-zero mantissa.
  function automatic logic fp_is_nan(input logic [7:0] x);
    return (x[6:3] == 4'hF) && (x[2:0] != 3'd0);
  endfunction

  // Infinity of either sign: exponent all ones, mantissa zero.
  function automatic logic fp_is_inf(input logic [7:0] x);
    return x[6:0] == 7'h78;
  endfunction

  // Zero of either sign.
  function automatic logic fp_is_zero(input logic [7:0] x);
    return x[6:0] == 7'h00;
  endfunction

  // Exception checker: NaN inputs and invalid operations (inf-inf, 0*inf).
  // Subtraction of same-signed infinities is the same invalid case as adding
  // opposite-signed ones.
  function automatic logic fp_exception(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic both_inf;
    logic exc;
    both_inf = fp_is_inf(a) && fp_is_inf(b);
    exc      = fp_is_nan(a) || fp_is_nan(b);
    case (op)
      OP_ADD:  exc = exc || (both_inf && (a[7] != b[7]));
      OP_SUB:  exc = exc || (both_inf && (a[7] == b[7]));
      OP_MUL:  exc = exc || (fp_is_zero(a) && fp_is_inf(b))
                         || (fp_is_inf(a) && fp_is_zero(b));
      default: exc = exc;
    endcase
    return exc;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [1:0]       core_op_r, core_op_nxt_s;
  logic [7:0]       core_a_r, core_a_nxt_s;
  logic [7:0]       core_b_r, core_b_nxt_s;
  logic             core_start_r, core_start_nxt_s;
  logic [7:0]       res_data_r, res_data_nxt_s;
  logic [1:0]       res_status_r, res_status_nxt_s;
  logic [7:0]       tmo_cnt_r, tmo_cnt_nxt_s;
  logic [CNT_W-1:0] exc_count_r, exc_count_nxt_s;

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    core_op_nxt_s    = core_op_r;
    core_a_nxt_s     = core_a_r;
    core_b_nxt_s     = core_b_r;
    core_start_nxt_s = 1'b0;
    res_data_nxt_s   = res_data_r;
    res_status_nxt_s = res_status_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    exc_count_nxt_s  = exc_count_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          core_op_nxt_s = in_op;
          core_a_nxt_s  = in_a;
          core_b_nxt_s  = in_b;
          state_nxt_s   = ST_CHECK;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_CHECK: begin
        // The illegal opcode is reported ahead of any FP exception.
        if (core_op_r == OP_ILL) begin
          res_status_nxt_s = ST_ILLEGAL;
          res_data_nxt_s   = CANON_NAN;
          state_nxt_s      = ST_RESP;
        end else if (fp_exception(core_op_r, core_a_r, core_b_r)) begin
          res_status_nxt_s = ST_FP_EXC;
          res_data_nxt_s   = CANON_NAN;
          state_nxt_s      = ST_RESP;
        end else begin
          core_start_nxt_s = 1'b1;
          state_nxt_s      = ST_DISPATCH;
        end
      end

      ST_DISPATCH: begin
        tmo_cnt_nxt_s = 8'd0;
        state_nxt_s   = ST_WAIT;
      end

      ST_WAIT: begin
        // A done arriving on the timeout edge still delivers the OK result.
        if (core_done) begin
          res_data_nxt_s   = core_result;
          res_status_nxt_s = ST_OK;
          state_nxt_s      = ST_RESP;
        end else if ((tmo_cnt_r + 8'd1) == TMO_LIMIT) begin
          tmo_cnt_nxt_s    = tmo_cnt_r + 8'd1;
          res_data_nxt_s   = CANON_NAN;
          res_status_nxt_s = ST_TIMEOUT;
          state_nxt_s      = ST_RESP;
        end else begin
          tmo_cnt_nxt_s    = tmo_cnt_r + 8'd1;
        end
      end

      ST_RESP: begin
        if (res_ready) begin
          state_nxt_s = ST_IDLE;
          if ((res_status_r != ST_OK) && (exc_count_r != CNT_MAX)) begin
            exc_count_nxt_s = exc_count_r + CNT_ONE;
          end else begin
            exc_count_nxt_s = exc_count_r;
          end
        end else begin
          state_nxt_s = ST_RESP;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      core_op_r    <= 2'b00;
      core_a_r     <= 8'h00;
      core_b_r     <= 8'h00;
      core_start_r <= 1'b0;
      res_data_r   <= 8'h00;
      res_status_r <= 2'b00;
      tmo_cnt_r    <= 8'd0;
      exc_count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      core_op_r    <= core_op_nxt_s;
      core_a_r     <= core_a_nxt_s;
      core_b_r     <= core_b_nxt_s;
      core_start_r <= core_start_nxt_s;
      res_data_r   <= res_data_nxt_s;
      res_status_r <= res_status_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      exc_count_r  <= exc_count_nxt_s;
    end
  end

  assign in_ready   = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign res_valid  = (state_r == ST_RESP);
  assign core_start = core_start_r;
  assign core_op    = core_op_r;
  assign core_a     = core_a_r;
  assign core_b     = core_b_r;
  assign res_data   = res_data_r;
  assign res_status = res_status_r;
  assign exc_count  = exc_count_r;

endmodule

// File: tb/tb_fpu8_op_sequencer.sv
// Directed testbench for fpu8_op_sequencer. Inputs are driven and outputs
// sampled on the falling clock edge; expected values are hand-computed.
module tb_fpu8_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       core_start;
  logic [1:0] core_op;
  logic [7:0] core_a;
  logic [7:0] core_b;
  logic       core_done;
  logic [7:0] core_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_status;
  logic       busy;
  logic [7:0] exc_count;

  int checks_r;
  int errors_r;

  fpu8_op_sequencer #(.CORE_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_status(res_status), .busy(busy), .exc_count(exc_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r = checks_r + 1;
    if (obs !== exp) begin
      errors_r = errors_r + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns on the negedge after the accept edge.
  task automatic accept(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Complete the response handshake; returns on the following negedge.
  task automatic respond;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [1:0] exc_op  [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [7:0] exc_a   [4] = '{8'h78, 8'h00, 8'h78, 8'h79};
  logic [7:0] exc_b   [4] = '{8'hF8, 8'h78, 8'h78, 8'h00};
  logic [1:0] exc_st  [4] = '{2'b01, 2'b01, 2'b01, 2'b10};

  initial begin
    int wait_cycles;
    checks_r    = 0;
    errors_r    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_op       = 2'b00;
    in_a        = 8'h00;
    in_b        = 8'h00;
    core_done   = 1'b0;
    core_result = 8'h00;
    res_ready   = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_core_start", {31'd0, core_start}, 32'd0);
    check_eq("rst_res_data", {24'd0, res_data}, 32'h00);
    check_eq("rst_exc_count", {24'd0, exc_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // OK path: 1.0 + 1.0, core answers 2.0 on the third WAIT cycle.
    accept(2'b00, 8'h38, 8'h38);
    check_eq("ok_busy_check", {31'd0, busy}, 32'd1);
    check_eq("ok_no_start_in_check", {31'd0, core_start}, 32'd0);
    @(negedge clk);
    check_eq("ok_core_start", {31'd0, core_start}, 32'd1);
    check_eq("ok_core_a", {24'd0, core_a}, 32'h38);
    check_eq("ok_core_b", {24'd0, core_b}, 32'h38);
    check_eq("ok_core_op", {30'd0, core_op}, 32'd0);
    @(negedge clk);
    check_eq("ok_start_one_cycle", {31'd0, core_start}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    core_done   = 1'b1;
    core_result = 8'h40;
    check_eq("ok_no_valid_before_done", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    core_done = 1'b0;
    check_eq("ok_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("ok_res_data", {24'd0, res_data}, 32'h40);
    check_eq("ok_res_status", {30'd0, res_status}, 32'd0);
    respond;
    check_eq("ok_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("ok_exc_count", {24'd0, exc_count}, 32'd0);

    // Exception and illegal requests answered directly with canonical NaN.
    for (int i = 0; i < 4; i++) begin
      accept(exc_op[i], exc_a[i], exc_b[i]);
      check_eq("exc_no_valid_early", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check_eq("exc_res_valid", {31'd0, res_valid}, 32'd1);
      check_eq("exc_no_core_start", {31'd0, core_start}, 32'd0);
      check_eq("exc_res_data", {24'd0, res_data}, 32'h7F);
      check_eq("exc_res_status", {30'd0, res_status}, {30'd0, exc_st[i]});
      respond;
      check_eq("exc_count_step", {24'd0, exc_count}, i + 1);
    end

    // Core never answers: timeout after exactly 15 WAIT cycles.
    accept(2'b01, 8'h40, 8'h38);
    @(negedge clk);
    check_eq("tmo_core_start", {31'd0, core_start}, 32'd1);
    wait_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valid) break;
      wait_cycles = wait_cycles + 1;
    end
    check_eq("tmo_wait_cycles", wait_cycles, 32'd15);
    check_eq("tmo_res_status", {30'd0, res_status}, 32'd3);
    check_eq("tmo_res_data", {24'd0, res_data}, 32'h7F);
    respond;
    check_eq("tmo_exc_count", {24'd0, exc_count}, 32'd5);

    // Done on the 15th WAIT cycle: OK result wins over the timeout.
    accept(2'b10, 8'h40, 8'h40);
    @(negedge clk);
    repeat (15) @(negedge clk);
    check_eq("race_no_valid_yet", {31'd0, res_valid}, 32'd0);
    core_done   = 1'b1;
    core_result = 8'h5A;
    @(negedge clk);
    core_done = 1'b0;
    check_eq("race_res_valid", {31'd0, res_valid}, 32'd1);
    check_eq("race_res_status", {30'd0, res_status}, 32'd0);
    check_eq("race_res_data", {24'd0, res_data}, 32'h5A);
    respond;
    check_eq("race_exc_count", {24'd0, exc_count}, 32'd5);

    // Back-pressure with a new request waiting.
    accept(2'b00, 8'h78, 8'hF8);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_a     = 8'h30;
    in_b     = 8'h38;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check_eq("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check_eq("bp_res_data", {24'd0, res_data}, 32'h7F);
      check_eq("bp_res_status", {30'd0, res_status}, 32'd1);
    end
    respond;
    check_eq("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("bp_exc_count", {24'd0, exc_count}, 32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_next_accepted", {31'd0, busy}, 32'd1);
    check_eq("bp_next_core_a", {24'd0, core_a}, 32'h30);
    @(negedge clk);
    check_eq("bp_next_start", {31'd0, core_start}, 32'd1);
    @(negedge clk);
    core_done   = 1'b1;
    core_result = 8'h3C;
    @(negedge clk);
    core_done = 1'b0;
    check_eq("bp_next_data", {24'd0, res_data}, 32'h3C);
    respond;

    // Reset during WAIT aborts; a late done produces nothing.
    accept(2'b00, 8'h38, 8'h38);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("arst_core_start", {31'd0, core_start}, 32'd0);
    check_eq("arst_core_a", {24'd0, core_a}, 32'h00);
    check_eq("arst_exc_count", {24'd0, exc_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_done   = 1'b1;
    core_result = 8'h55;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check_eq("late_done_no_valid", {31'd0, res_valid}, 32'd0);
    check_eq("late_done_idle", {31'd0, busy}, 32'd0);

    // Saturation of the exception counter.
    for (int i = 0; i < 256; i++) begin
      accept(2'b11, 8'h00, 8'h00);
      @(negedge clk);
      respond;
      if (i == 254) check_eq("sat_at_255", {24'd0, exc_count}, 32'hFF);
    end
    check_eq("sat_hold", {24'd0, exc_count}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
